bluetooth_decoder: RTL and testbench

BLUETOOTH_DECODER -- requirements
Module: bluetooth_decoder

---
 rtl/bluetooth_decoder_if.sv | 22 ++
 rtl/bluetooth_decoder.sv | 143 ++++++++++++++
 tb/tb_bluetooth_decoder.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/bluetooth_decoder_if.sv
// Byte-stream and decoded-result bundle for the BLE UART frame decoder.
// The byte source has no ready; every valid byte with enable high is taken.
interface bluetooth_decoder_if;
  logic        enable;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic [31:0] output_data;
  logic [3:0]  command_select;
  logic        done;
  logic        error;
  logic        busy;

  modport master (
    output enable, byte_in, byte_valid,
    input  output_data, command_select, done, error, busy
  );

  modport slave (
    input  enable, byte_in, byte_valid,
    output output_data, command_select, done, error, busy
  );
endinterface

// File: rtl/bluetooth_decoder.sv
// Decodes 16-byte "AT+BLEUART<T|R>X<4 payload>" frames into a 32-bit word and command.
// done is 1 clock after the last payload byte; no backpressure, bytes are taken when valid.
module bluetooth_decoder #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                reset,
  bluetooth_decoder_if.slave  bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, PREFIX, PAYLOAD, DONE, ERR} state_t;

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic        resync_q, resync_d;
  logic [3:0]  type_q, type_d;
  logic [23:0] pay_q, pay_d;
  logic [31:0] data_q;
  logic [3:0]  cmd_q;
  logic        load_out;

  logic        consume;
  logic        in_prefix;
  logic [3:0]  cur_idx;
  logic        prefix_match;
  logic        tmo_hit;

  function automatic logic [7:0] exp_byte(input logic [3:0] i);
    case (i)
      4'd0:    exp_byte = 8'h41;
      4'd1:    exp_byte = 8'h54;
      4'd2:    exp_byte = 8'h2B;
      4'd3:    exp_byte = 8'h42;
      4'd4:    exp_byte = 8'h4C;
      4'd5:    exp_byte = 8'h45;
      4'd6:    exp_byte = 8'h55;
      4'd7:    exp_byte = 8'h41;
      4'd8:    exp_byte = 8'h52;
      4'd9:    exp_byte = 8'h54;
      4'd11:   exp_byte = 8'h58;
      default: exp_byte = 8'h00;
    endcase
  endfunction

  assign consume   = bus.byte_valid & bus.enable;
  // An ERR entered on a stray 0x41 already holds byte 0 of the next frame.
  assign in_prefix = (state_q == PREFIX) || ((state_q == ERR) && resync_q);
  assign cur_idx   = (state_q == ERR) ? 4'd1 : idx_q;
  assign prefix_match = (cur_idx == 4'd10) ? ((bus.byte_in == 8'h54) || (bus.byte_in == 8'h52))
                                           : (bus.byte_in == exp_byte(cur_idx));
  assign tmo_hit   = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    tmo_d    = tmo_q;
    resync_d = 1'b0;
    type_d   = type_q;
    pay_d    = pay_q;
    load_out = 1'b0;

    if (!bus.enable) begin
      state_d = IDLE;
      idx_d   = 4'd0;
      tmo_d   = '0;
    end else if (in_prefix || (state_q == PAYLOAD)) begin
      if (consume) begin
        tmo_d = '0;
        if (state_q == PAYLOAD) begin
          if (idx_q == 4'd15) begin
            state_d  = DONE;
            idx_d    = 4'd0;
            load_out = 1'b1;
          end else begin
            pay_d[{idx_q[1:0], 3'b000} +: 8] = bus.byte_in;
            idx_d = idx_q + 4'd1;
          end
        end else if (prefix_match) begin
          state_d = (cur_idx == 4'd11) ? PAYLOAD : PREFIX;
          idx_d   = cur_idx + 4'd1;
          if (cur_idx == 4'd10)
            type_d = (bus.byte_in == 8'h54) ? 4'h1 : 4'h2;
        end else begin
          state_d  = ERR;
          idx_d    = 4'd0;
          resync_d = (bus.byte_in == 8'h41);
        end
      end else if (tmo_hit) begin
        state_d = ERR;
        idx_d   = 4'd0;
        tmo_d   = '0;
      end else begin
        state_d = (state_q == ERR) ? PREFIX : state_q;
        idx_d   = cur_idx;
        tmo_d   = tmo_q + TW'(1);
      end
    end else begin
      tmo_d = '0;
      if (consume && (bus.byte_in == 8'h41)) begin
        state_d = PREFIX;
        idx_d   = 4'd1;
      end else begin
        state_d = IDLE;
        idx_d   = 4'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= 4'd0;
      tmo_q    <= '0;
      resync_q <= 1'b0;
      type_q   <= 4'h0;
      pay_q    <= 24'h0;
      data_q   <= 32'h0;
      cmd_q    <= 4'h0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      tmo_q    <= tmo_d;
      resync_q <= resync_d;
      type_q   <= type_d;
      pay_q    <= pay_d;
      if (load_out) begin
        data_q <= {bus.byte_in, pay_q};
        cmd_q  <= type_q;
      end
    end
  end

  assign bus.output_data    = data_q;
  assign bus.command_select = cmd_q;
  assign bus.done           = (state_q == DONE);
  assign bus.error          = (state_q == ERR);
  assign bus.busy           = (state_q == PREFIX) || (state_q == PAYLOAD) ||
                              ((state_q == ERR) && resync_q);

endmodule

// File: tb/tb_bluetooth_decoder.sv
// Directed bench for bluetooth_decoder: table of whole frames plus hand sequences
// for resync, timeout, enable drop and mid-frame reset.
module tb_bluetooth_decoder;

  localparam int T = 20;

  logic clk;
  logic reset;
  bluetooth_decoder_if bus ();

  bluetooth_decoder #(.TIMEOUT_CYCLES(T)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  typ;
    logic [31:0] pay;
    int          gap;
    logic        exp_done;
    logic        exp_err;
    logic [31:0] exp_data;
    logic [3:0]  exp_cmd;
  } vec_t;

  vec_t       vecs [7];
  logic [7:0] pfx [10];
  int total, bad;
  int done_cnt, err_cnt;
  logic last_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
    last_done = bus.done;
    if (bus.done)  done_cnt++;
    if (bus.error) err_cnt++;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    tick();
    bus.byte_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_pfx(input int from, input int to, input int gap);
    for (int i = from; i <= to; i++) send_byte(pfx[i], gap);
  endtask

  task automatic send_frame(input logic [7:0] typ, input logic [31:0] pay, input int gap);
    send_pfx(0, 9, gap);
    send_byte(typ, gap);
    send_byte(8'h58, gap);
    for (int i = 0; i < 4; i++) send_byte(pay[8*i +: 8], (i == 3) ? 0 : gap);
  endtask

  initial begin
    int d0, e0, n;
    logic got, busy_at_err;

    total = 0; bad = 0; done_cnt = 0; err_cnt = 0; last_done = 1'b0;
    pfx = '{8'h41, 8'h54, 8'h2B, 8'h42, 8'h4C, 8'h45, 8'h55, 8'h41, 8'h52, 8'h54};
    vecs[0] = '{8'h54, 32'h44332211, 0,  1'b1, 1'b0, 32'h44332211, 4'h1};
    vecs[1] = '{8'h52, 32'hEFBEADDE, 3,  1'b1, 1'b0, 32'hEFBEADDE, 4'h2};
    vecs[2] = '{8'h51, 32'h01020304, 0,  1'b0, 1'b1, 32'hEFBEADDE, 4'h2};
    vecs[3] = '{8'h54, 32'h41414141, 1,  1'b1, 1'b0, 32'h41414141, 4'h1};
    vecs[4] = '{8'h52, 32'h00000000, 0,  1'b1, 1'b0, 32'h00000000, 4'h2};
    vecs[5] = '{8'h54, 32'hFFFFFFFF, T-1, 1'b1, 1'b0, 32'hFFFFFFFF, 4'h1};
    vecs[6] = '{8'h58, 32'h10203040, 0,  1'b0, 1'b1, 32'hFFFFFFFF, 4'h1};

    reset = 1'b1;
    bus.enable = 1'b1;
    bus.byte_valid = 1'b0;
    bus.byte_in = 8'h00;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_data", bus.output_data, 32'h0);
    chk("rst_cmd", {28'h0, bus.command_select}, 32'h0);
    chk("rst_done", {31'h0, bus.done}, 32'h0);
    chk("rst_err", {31'h0, bus.error}, 32'h0);
    chk("rst_busy", {31'h0, bus.busy}, 32'h0);

    for (int k = 0; k < 7; k++) begin
      d0 = done_cnt; e0 = err_cnt;
      send_frame(vecs[k].typ, vecs[k].pay, vecs[k].gap);
      chk($sformatf("v%0d_done_lat", k), {31'h0, last_done}, {31'h0, vecs[k].exp_done});
      repeat (2) tick();
      chk($sformatf("v%0d_done_cnt", k), done_cnt - d0, {31'h0, vecs[k].exp_done});
      chk($sformatf("v%0d_err_cnt", k), err_cnt - e0, {31'h0, vecs[k].exp_err});
      chk($sformatf("v%0d_data", k), bus.output_data, vecs[k].exp_data);
      chk($sformatf("v%0d_cmd", k), {28'h0, bus.command_select}, {28'h0, vecs[k].exp_cmd});
    end

    // Second 'A' of "AT+BLA" aborts and restarts the frame.
    d0 = done_cnt; e0 = err_cnt;
    send_pfx(0, 4, 0);
    send_byte(8'h41, 0);
    send_pfx(1, 9, 0);
    send_byte(8'h54, 0);
    send_byte(8'h58, 0);
    send_byte(8'hBE, 0); send_byte(8'hBA, 0); send_byte(8'hFE, 0); send_byte(8'hCA, 0);
    chk("resync_done_lat", {31'h0, last_done}, 32'h1);
    repeat (2) tick();
    chk("resync_err_cnt", err_cnt - e0, 32'h1);
    chk("resync_done_cnt", done_cnt - d0, 32'h1);
    chk("resync_data", bus.output_data, 32'hCAFEBABE);
    chk("resync_cmd", {28'h0, bus.command_select}, 32'h1);

    // Idle timeout mid-prefix.
    d0 = done_cnt; e0 = err_cnt;
    send_pfx(0, 5, 0);
    chk("tmo_busy_pre", {31'h0, bus.busy}, 32'h1);
    n = 0; got = 1'b0; busy_at_err = 1'b1;
    while (!got && n < 100) begin
      tick();
      n++;
      if (bus.error) begin
        got = 1'b1;
        busy_at_err = bus.busy;
      end
    end
    chk("tmo_seen", {31'h0, got}, 32'h1);
    chk("tmo_window", {31'h0, (n >= T-1 && n <= T+2)}, 32'h1);
    chk("tmo_busy_at_err", {31'h0, busy_at_err}, 32'h0);
    tick();
    chk("tmo_busy_after", {31'h0, bus.busy}, 32'h0);
    send_byte(8'h52, 0); send_byte(8'h54, 0); send_byte(8'h54, 0); send_byte(8'h58, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    repeat (2) tick();
    chk("tmo_stale_done", done_cnt - d0, 32'h0);
    chk("tmo_err_cnt", err_cnt - e0, 32'h1);
    chk("tmo_data_kept", bus.output_data, 32'hCAFEBABE);

    // enable low mid-frame aborts silently.
    d0 = done_cnt; e0 = err_cnt;
    send_pfx(0, 7, 0);
    bus.enable = 1'b0;
    tick();
    chk("en_busy", {31'h0, bus.busy}, 32'h0);
    bus.enable = 1'b1;
    send_byte(8'h52, 0); send_byte(8'h54, 0); send_byte(8'h54, 0); send_byte(8'h58, 0);
    send_byte(8'h55, 0); send_byte(8'h66, 0); send_byte(8'h77, 0); send_byte(8'h88, 0);
    repeat (2) tick();
    chk("en_err_cnt", err_cnt - e0, 32'h0);
    chk("en_done_cnt", done_cnt - d0, 32'h0);
    send_frame(8'h52, 32'h13572468, 0);
    chk("en_after_done_lat", {31'h0, last_done}, 32'h1);
    chk("en_after_data", bus.output_data, 32'h13572468);

    // Reset after 14 bytes discards the partial frame.
    tick();
    d0 = done_cnt;
    send_pfx(0, 9, 0);
    send_byte(8'h54, 0); send_byte(8'h58, 0);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk("mrst_data", bus.output_data, 32'h0);
    chk("mrst_busy", {31'h0, bus.busy}, 32'h0);
    send_byte(8'hCC, 0); send_byte(8'hDD, 0);
    repeat (2) tick();
    chk("mrst_no_done", done_cnt - d0, 32'h0);
    send_frame(8'h54, 32'h87654321, 0);
    chk("mrst_done_lat", {31'h0, last_done}, 32'h1);
    repeat (2) tick();
    chk("mrst_done_cnt", done_cnt - d0, 32'h1);
    chk("mrst_data_new", bus.output_data, 32'h87654321);
    chk("mrst_cmd", {28'h0, bus.command_select}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
